// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the control unit and the multiply/divide sequencer.
// Build option MULDIV_UNSIGNED_EN adds the op_unsigned request bit.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op_div;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
`ifdef MULDIV_UNSIGNED_EN
   logic             op_unsigned;
`endif
   logic             busy;
   logic             done;
   logic             hi_w;
   logic             lo_w;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             div0_exc;

   modport master (
      output start, op_div, op_a, op_b,
`ifdef MULDIV_UNSIGNED_EN
      output op_unsigned,
`endif
      input  busy, done, hi_w, lo_w, hi_out, lo_out, div0_exc
   );

   modport slave (
      input  start, op_div, op_a, op_b,
`ifdef MULDIV_UNSIGNED_EN
      input  op_unsigned,
`endif
      output busy, done, hi_w, lo_w, hi_out, lo_out, div0_exc
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide with HI/LO write strobes and divide-by-zero exception.
// Build option MULDIV_UNSIGNED_EN enables MULTU/DIVU via op_unsigned; otherwise all operations are signed.
//
// state | meaning
// IDLE  | waiting for start, operands latched on accept
// PREP  | take magnitudes, record signs, trap divide by zero
// RUN   | one multiply/divide iteration per cycle, WIDTH cycles
// FIX   | apply result signs, load HI/LO
// DONE  | done/hi_w/lo_w high for one cycle
// EXC   | div0_exc high for one cycle
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   muldiv_sequencer_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE, S_EXC} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             div_q, div_d, uns_q, uns_d;
   logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] work_q, work_d, mag_b_q, mag_b_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             busy_q, busy_d, done_q, done_d, exc_q, exc_d;

   logic [WIDTH:0]     mul_sum, rem_sh;
   logic [WIDTH+1:0]   rem_diff;
   logic [2*WIDTH-1:0] prod_raw, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic               last_iter, borrow;

`ifdef MULDIV_UNSIGNED_EN
   assign uns_d = (state_q == S_IDLE && bus.start) ? bus.op_unsigned : uns_q;
`else
   assign uns_d = 1'b0;
`endif

   always_comb begin
      // acc holds the running high half (multiply) or partial remainder (divide)
      mul_sum   = acc_q + {1'b0, (work_q[0] ? mag_b_q : {WIDTH{1'b0}})};
      rem_sh    = {acc_q[WIDTH-1:0], work_q[WIDTH-1]};
      rem_diff  = {1'b0, rem_sh} - {2'b00, mag_b_q};
      borrow    = rem_diff[WIDTH+1];
      prod_raw  = {acc_q[WIDTH-1:0], work_q};
      prod_fix  = (sign_a_q ^ sign_b_q) ? -prod_raw : prod_raw;
      quo_fix   = (sign_a_q ^ sign_b_q) ? -work_q : work_q;
      rem_fix   = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      last_iter = (cnt_q == CW'(WIDTH - 1));

      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      a_d      = a_q;
      b_d      = b_q;
      work_d   = work_q;
      mag_b_d  = mag_b_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      exc_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               div_d   = bus.op_div;
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               busy_d  = 1'b1;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            // 0x80000000 negates to itself, which is the correct unsigned magnitude 2^31
            sign_a_d = ~uns_q & a_q[WIDTH-1];
            sign_b_d = ~uns_q & b_q[WIDTH-1];
            work_d   = sign_a_d ? -a_q : a_q;
            mag_b_d  = sign_b_d ? -b_q : b_q;
            acc_d    = '0;
            cnt_d    = '0;
            if (div_q && b_q == '0) begin
               exc_d   = 1'b1;
               state_d = S_EXC;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = last_iter ? '0 : cnt_q + CW'(1);
            if (div_q) begin
               acc_d  = borrow ? rem_sh : rem_diff[WIDTH:0];
               work_d = {work_q[WIDTH-2:0], ~borrow};
            end else begin
               acc_d  = {1'b0, mul_sum[WIDTH:1]};
               work_d = {mul_sum[0], work_q[WIDTH-1:1]};
            end
            if (last_iter) state_d = S_FIX;
         end
         S_FIX: begin
            if (div_q) begin
               lo_d = quo_fix;
               hi_d = rem_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_EXC: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         div_q    <= 1'b0;
         uns_q    <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         work_q   <= '0;
         mag_b_q  <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         uns_q    <= uns_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         a_q      <= a_d;
         b_q      <= b_d;
         work_q   <= work_d;
         mag_b_q  <= mag_b_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         exc_q    <= exc_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.hi_w     = done_q;
   assign bus.lo_w     = done_q;
   assign bus.hi_out   = hi_q;
   assign bus.lo_out   = lo_q;
   assign bus.div0_exc = exc_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: latency, results, div-by-zero, ignored start, mid-op reset.
// Build with MULDIV_UNSIGNED_EN to also exercise the unsigned operations.
module tb_muldiv_sequencer;
   logic clk = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(32)) bus ();

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one operation; wait (bounded) for done or div0_exc and check latency and results.
   task automatic run_op(input string tag, input logic dv, input logic [31:0] a, input logic [31:0] b,
                         input logic exc, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int repulse);
      int   k;
      logic got;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op_div = dv;
      bus.op_a   = a;
      bus.op_b   = b;
      @(posedge clk);
      #1;
      chk($sformatf("%s_busy_e0", tag), 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      bus.op_a  = ~a;
      bus.op_b  = ~b;
      k   = 0;
      got = 1'b0;
      while (!got && k < 60) begin
         @(posedge clk);
         #1;
         k++;
         bus.start = (k == repulse);
         if (bus.done || bus.div0_exc) got = 1'b1;
      end
      bus.start = 1'b0;
      chk($sformatf("%s_latency", tag), 64'(k), exc ? 64'd1 : 64'd34);
      chk($sformatf("%s_div0", tag), 64'(bus.div0_exc), 64'(exc));
      chk($sformatf("%s_done", tag), 64'(bus.done), 64'(!exc));
      chk($sformatf("%s_hi", tag), 64'(bus.hi_out), 64'(exp_hi));
      chk($sformatf("%s_lo", tag), 64'(bus.lo_out), 64'(exp_lo));
      chk($sformatf("%s_strobes", tag), 64'({bus.hi_w, bus.lo_w}), exc ? 64'd0 : 64'd3);
      @(posedge clk);
      #1;
      chk($sformatf("%s_end_pulses", tag), 64'({bus.done, bus.hi_w, bus.lo_w, bus.div0_exc}), 64'd0);
      chk($sformatf("%s_busy_end", tag), 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int n_done;
      reset_n    = 1'b0;
      bus.start  = 1'b0;
      bus.op_div = 1'b0;
      bus.op_a   = '0;
      bus.op_b   = '0;
`ifdef MULDIV_UNSIGNED_EN
      bus.op_unsigned = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'({bus.done, bus.hi_w, bus.lo_w}), 64'd0);
      chk("rst_div0", 64'(bus.div0_exc), 64'd0);
      chk("rst_hi", 64'(bus.hi_out), 64'd0);
      chk("rst_lo", 64'(bus.lo_out), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run_op("mul_7x-3",     1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
      run_op("mul_max",      1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001, 0);
      run_op("div_-7/2",     1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      run_op("div_5/0",      1'b1, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      run_op("div_min/-1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, 0);
      run_op("div_0/5",      1'b1, 32'h0000_0000, 32'h0000_0005, 1'b0, 32'h0000_0000, 32'h0000_0000, 0);
      run_op("mul_min_sq",   1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000, 0);
      run_op("div_100/-7",   1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0, 32'h0000_0002, 32'hFFFF_FFF2, 0);
      run_op("mul_repulse",  1'b0, 32'h0000_0007, 32'h0000_0006, 1'b0, 32'h0000_0000, 32'h0000_002A, 10);

      n_done = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) n_done++;
      end
      chk("repulse_no_second_done", 64'(n_done), 64'd0);

      // Reset in the middle of a running multiply
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op_div = 1'b0;
      bus.op_a   = 32'h0000_0003;
      bus.op_b   = 32'h0000_0005;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (19) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_hi", 64'(bus.hi_out), 64'd0);
      chk("midrst_lo", 64'(bus.lo_out), 64'd0);
      chk("midrst_pulses", 64'({bus.done, bus.hi_w, bus.lo_w, bus.div0_exc}), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      n_done = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) n_done++;
      end
      chk("midrst_no_done", 64'(n_done), 64'd0);

      run_op("mul_-3x-3",    1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0, 32'h0000_0000, 32'h0000_0009, 0);

`ifdef MULDIV_UNSIGNED_EN
      bus.op_unsigned = 1'b1;
      run_op("mulu_ffx2",    1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 0);
      run_op("divu_ff/2",    1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'h7FFF_FFFF, 0);
      run_op("divu_5/0",     1'b1, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0001, 32'h7FFF_FFFF, 0);
      bus.op_unsigned = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
